// File: rtl/shaper_peak_reconstructor.sv
// Peak detector and energy reconstructor for the shaped-pulse stream.
// Detected events {energy, bc} queue in a first-word-fall-through FIFO drained by valid/ready.
module shaper_peak_reconstructor #(
  parameter int BITS_IN      = 30,
  parameter int ENG_OUT_BITS = 13,
  parameter int SHIFT_OUT    = 16,
  parameter int THRESH       = 327680,
  parameter int BUNCH_POS    = 3564,
  parameter int BC_BITS      = 12,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic signed [BITS_IN-1:0]            in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ENG_OUT_BITS-1:0]              energy_out,
  output logic [BC_BITS-1:0]                   bc_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic [15:0]                          drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int EV_W  = ENG_OUT_BITS + BC_BITS;

  localparam logic signed [BITS_IN-1:0] THR     = BITS_IN'(THRESH);
  localparam logic signed [BITS_IN-1:0] ENG_MAX = BITS_IN'((1 << ENG_OUT_BITS) - 1);

  // x0 = newest sample x_k, x1 = candidate centre x_{k-1}, x2 = x_{k-2}
  logic signed [BITS_IN-1:0] x0, x1, x2;
  logic [BC_BITS-1:0]        t0, t1;
  logic [BC_BITS-1:0]        bc_next;
  logic [1:0]                fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      t0      <= '0;
      t1      <= '0;
      bc_next <= '0;
      fill    <= '0;
    end else begin
      x2 <= x1;
      x1 <= x0;
      x0 <= in;
      t1 <= t0;
      t0 <= bc_next;
      if (bc_next == BC_BITS'(BUNCH_POS - 1))
        bc_next <= '0;
      else
        bc_next <= bc_next + BC_BITS'(1);
      if (fill != 2'd3)
        fill <= fill + 2'd1;
    end
  end

  logic                      peak;
  logic signed [BITS_IN-1:0] shifted;
  logic [ENG_OUT_BITS-1:0]   eng;

  // Strict rise on the left, non-strict on the right: only the first sample of a flat top qualifies.
  always_comb begin
    peak    = (fill == 2'd3) && (x1 > THR) && (x1 > x2) && (x1 >= x0);
    shifted = x1 >>> SHIFT_OUT;
    eng     = '0;
    if (shifted[BITS_IN-1])
      eng = '0;
    else if (shifted > ENG_MAX)
      eng = '1;
    else
      eng = shifted[ENG_OUT_BITS-1:0];
  end

  logic [EV_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, pop, wr_en, drop;
  logic [EV_W-1:0]  head;

  always_comb begin
    out_valid = (fifo_count != '0);
    full      = (fifo_count == CNT_W'(FIFO_DEPTH));
    pop       = out_valid & out_ready;
    // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
    wr_en     = peak & (~full | pop);
    drop      = peak & full & ~pop;
    head      = mem[rd_ptr];
    energy_out = '0;
    bc_out     = '0;
    if (out_valid) begin
      energy_out = head[EV_W-1:BC_BITS];
      bc_out     = head[BC_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {eng, t1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop && drop_count != '1)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_shaper_peak_reconstructor.sv
// Scoreboard bench for shaper_peak_reconstructor: expected events are queued as
// pulses are driven and compared against the FIFO head on every handshake.
module tb_shaper_peak_reconstructor;

  localparam int BITS_IN = 30;
  localparam int ENG     = 13;
  localparam int BCB     = 12;
  localparam int BPOS    = 3564;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic signed [BITS_IN-1:0] in_s = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [ENG-1:0]            energy_out;
  logic [BCB-1:0]            bc_out;
  logic [4:0]                fifo_count;
  logic [15:0]               drop_count;

  shaper_peak_reconstructor #(
    .BITS_IN(30), .ENG_OUT_BITS(13), .SHIFT_OUT(16), .THRESH(327680),
    .BUNCH_POS(3564), .BC_BITS(12), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .in(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .energy_out(energy_out), .bc_out(bc_out),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { int e; int bc; } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int k_next = 0;
  bit toggle = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one sample, lets it be captured, returns at the next negedge.
  task automatic step(input int x);
    in_s = x[BITS_IN-1:0];
    if (toggle) out_ready = ~out_ready;
    @(posedge clk);
    k_next++;
    @(negedge clk);
  endtask

  task automatic pulse(input int p, input bit expect_ev);
    int e;
    e = p >>> 16;
    if (e > 8191) e = 8191;
    if (e < 0) e = 0;
    step(0);
    if (expect_ev) exp_q.push_back('{e, k_next % BPOS});
    step(p);
    step(0);
  endtask

  // Handshake monitor: samples between drive (negedge) and the next active edge.
  initial begin
    ev_t        ev;
    bit         stall_prev = 1'b0;
    logic [31:0] prev_e = '0, prev_bc = '0;
    forever begin
      @(negedge clk);
      #3;
      if (stall_prev && out_valid) begin
        check_eq("stall_energy", {19'd0, energy_out}, prev_e);
        check_eq("stall_bc", {20'd0, bc_out}, prev_bc);
      end
      if (out_valid && out_ready) begin
        check_eq("pending_on_pop", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          check_eq("energy", {19'd0, energy_out}, ev.e);
          check_eq("bc", {20'd0, bc_out}, ev.bc);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_e     = {19'd0, energy_out};
      prev_bc    = {20'd0, bc_out};
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {31'd0, out_valid}, 0);
    check_eq("rst_count", {27'd0, fifo_count}, 0);
    check_eq("rst_drop", {16'd0, drop_count}, 0);
    check_eq("rst_energy", {19'd0, energy_out}, 0);
    check_eq("rst_bc", {20'd0, bc_out}, 0);
    rst = 1'b1;
    k_next = 0;
    out_ready = 1'b1;

    // Single pulse: peak 300 at k=3, visible after edge 5
    step(0); step(0); step(100 << 16);
    exp_q.push_back('{300, 3});
    step(300 << 16); step(200 << 16);
    check_eq("valid_after_edge4", {31'd0, out_valid}, 0);
    step(0);
    check_eq("valid_after_edge5", {31'd0, out_valid}, 1);
    step(0);
    check_eq("single_count", {27'd0, fifo_count}, 0);

    // Flat top: first equal sample qualifies
    step(0);
    exp_q.push_back('{300, k_next % BPOS});
    step(300 << 16); step(300 << 16); step(0); step(0);

    // Threshold: equal is rejected, one above accepted
    pulse(5 << 16, 1'b0);
    pulse((5 << 16) + 1, 1'b1);
    // Saturation edge and truncation of fractional bits
    pulse((1 << 29) - 1, 1'b1);
    pulse((7 << 16) + 65535, 1'b1);
    repeat (3) step(0);
    check_eq("thresh_drop", {16'd0, drop_count}, 0);
    check_eq("drain1_count", {27'd0, fifo_count}, 0);
    check_eq("drain1_queue", exp_q.size(), 0);

    // FIFO full: 20 pulses, 16 kept
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) pulse((10 + i) << 16, i < 16);
    step(0); step(0);
    check_eq("full_count", {27'd0, fifo_count}, 16);
    check_eq("full_drop", {16'd0, drop_count}, 4);
    out_ready = 1'b1;
    repeat (20) step(0);
    check_eq("full_drained_valid", {31'd0, out_valid}, 0);
    check_eq("full_drained_queue", exp_q.size(), 0);

    // Backpressure: ready toggles every cycle
    toggle = 1'b1;
    for (int i = 0; i < 6; i++) pulse((40 + i) << 16, 1'b1);
    repeat (12) step(0);
    toggle = 1'b0;
    out_ready = 1'b1;
    repeat (4) step(0);
    check_eq("toggle_queue", exp_q.size(), 0);
    check_eq("toggle_count", {27'd0, fifo_count}, 0);

    // BC wrap: peaks at k=3563 (bc 3563) and k=7128 (bc 0)
    while (k_next != 3562) step(0);
    pulse(50 << 16, 1'b1);
    while (k_next != 7127) step(0);
    pulse(60 << 16, 1'b1);
    repeat (4) step(0);
    check_eq("wrap_queue", exp_q.size(), 0);

    // Async reset with events buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse((70 + i) << 16, 1'b1);
    step(0); step(0);
    check_eq("pre_rst_count", {27'd0, fifo_count}, 3);
    #1 rst = 1'b0;
    #1;
    check_eq("async_valid", {31'd0, out_valid}, 0);
    check_eq("async_count", {27'd0, fifo_count}, 0);
    check_eq("async_drop", {16'd0, drop_count}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    k_next = 0;
    out_ready = 1'b1;
    step(0);
    exp_q.push_back('{80, 2});
    step(0); step(80 << 16); step(0);
    repeat (4) step(0);
    check_eq("post_rst_queue", exp_q.size(), 0);
    check_eq("post_rst_count", {27'd0, fifo_count}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
